uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_param.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
// The PAR state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PAR,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Oversample divisor, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int unsigned DIV = 326
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// 16x-oversampled UART receiver with ready/valid output and error pulses.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS) + 1;

  rx_state_e            state, state_d;
  logic                 rx_meta, rx_s, rx_prev;
  logic                 tick, start_c, vote_c, bit_c;
  logic                 ld_c, ferr_c;
  logic [OS_W-1:0]      os_cnt;
  logic [1:0]           votes;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_c = (state == IDLE) && rx_prev && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_c),
    .tick    (tick)
  );

  // Bit decision happens on oversample 9 using samples 7, 8 and the live 9.
  assign vote_c = tick && (os_cnt == OS_W'(9));
  assign bit_c  = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

`ifdef UART_RX_PARITY_EN
  logic perr_c, par_bad;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    ld_c    = 1'b0;
    ferr_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_c  = 1'b0;
`endif
    case (state)
      IDLE:  if (start_c) state_d = START;
      START: if (vote_c) state_d = bit_c ? IDLE : DATA;
      DATA: begin
        if (vote_c && (bit_cnt == BC_W'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (vote_c) begin
          perr_c  = bit_c != ((^shreg) ^ 1'(PARITY_ODD));
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (vote_c) begin
          if (!bit_c) begin
            ferr_c  = 1'b1;
            state_d = WAIT_HIGH;
          end else if (bit_cnt == BC_W'(STOP_BITS - 1)) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            ld_c    = !par_bad;
`else
            ld_c    = 1'b1;
`endif
          end
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Oversample position, vote samples, per-state bit count and data shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt  <= '0;
      votes   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (start_c)   os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + OS_W'(1);
      if (tick && (os_cnt == OS_W'(7))) votes[0] <= rx_s;
      if (tick && (os_cnt == OS_W'(8))) votes[1] <= rx_s;
      if (state_d != state) bit_cnt <= '0;
      else if (vote_c)      bit_cnt <= bit_cnt + BC_W'(1);
      if ((state == DATA) && vote_c) shreg <= {bit_c, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_c;
      if (start_c)     par_bad <= 1'b0;
      else if (perr_c) par_bad <= 1'b1;
    end
  end
`else
  localparam int unsigned unused_parity_odd = PARITY_ODD;
  assign parity_err = 1'b0;
`endif

  // A completed word loads if the holding register is free or draining this clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_c;
      overrun   <= ld_c && m_valid && !m_ready;
      if (ld_c && (!m_valid || m_ready)) begin
        m_data  <= shreg;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomized self-checking bench for uart_rx_param against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ     = 6_400_000;
  localparam int unsigned BAUD       = 100_000;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned PARITY_ODD = 0;
  localparam int BIT = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int NBITS = 1 + DATA_BITS + NPAR + STOP_BITS;

  logic clk, rst, rx, m_valid, m_ready, frame_err, overrun, parity_err;
  logic [DATA_BITS-1:0] m_data;

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
    .STOP_BITS(STOP_BITS), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observation side: sampled on the falling edge, inputs change just after rising edges.
  int cyc = 0, frame_t0 = 0;
  int rises = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, stab_viol = 0;
  logic mv_q = 1'b0, prev_hold = 1'b0;
  logic [DATA_BITS-1:0] prev_data = '0;
  logic [DATA_BITS-1:0] got_q[$];

  always @(negedge clk) begin
    cyc++;
    if (m_valid && !mv_q) begin
      rises++;
      check("latency", 32'((cyc - frame_t0 >= (NBITS - 1) * BIT + BIT / 2) &&
                           (cyc - frame_t0 <= NBITS * BIT)), 32'd1);
    end
    if (m_valid && m_ready && !rst) got_q.push_back(m_data);
    if (frame_err)  n_ferr++;
    if (overrun)    n_ovr++;
    if (parity_err) n_perr++;
    if (prev_hold && (!m_valid || m_data !== prev_data)) stab_viol++;
    prev_hold = m_valid && !m_ready && !rst;
    prev_data = m_data;
    mv_q      = m_valid;
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    tick_n(n);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop_ok, input bit par_ok);
    frame_t0 = cyc;
    drive(1'b0, BIT);
    for (int i = 0; i < int'(DATA_BITS); i++) drive(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ 1'(PARITY_ODD) ^ !par_ok, BIT);
`endif
    for (int s = 0; s < int'(STOP_BITS); s++) drive(stop_ok, BIT);
  endtask

  task automatic clear_mon();
    rises = 0; n_ferr = 0; n_ovr = 0; n_perr = 0;
    got_q.delete();
  endtask

  task automatic check_one_word(input string tag, input logic [DATA_BITS-1:0] exp);
    check({tag, "_count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check({tag, "_data"}, 32'(got_q[0]), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [DATA_BITS-1:0] exp_q[$];
  int exp_ferr, exp_perr;

  initial begin
    rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
    tick_n(3);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_flags", 32'({frame_err, overrun, parity_err}), 32'd0);
    rst = 1'b0;
    drive(1'b1, BIT);

    // Clean 0x55.
    clear_mon();
    send_frame(8'h55, 1'b1, 1'b1);
    drive(1'b1, 2 * BIT);
    check_one_word("f55", 8'h55);
    check("f55_rises", 32'(rises), 32'd1);
    check("f55_flags", 32'(n_ferr + n_ovr + n_perr), 32'd0);

    // Short glitch is a false start, then 0xA3.
    clear_mon();
    drive(1'b0, 6);
    drive(1'b1, 2 * BIT);
    check("glitch_rises", 32'(rises), 32'd0);
    check("glitch_flags", 32'(n_ferr + n_ovr + n_perr), 32'd0);
    send_frame(8'hA3, 1'b1, 1'b1);
    drive(1'b1, BIT);
    check_one_word("fa3", 8'hA3);

    // Bad stop bit with a held break, then 0x81.
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b1);
    drive(1'b0, 3 * BIT);
    drive(1'b1, BIT);
    check("ferr_count", 32'(n_ferr), 32'd1);
    check("ferr_rises", 32'(rises), 32'd0);
    send_frame(8'h81, 1'b1, 1'b1);
    drive(1'b1, BIT);
    check_one_word("f81", 8'h81);

    // Overrun: second word dropped while the first waits.
    clear_mon();
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    drive(1'b1, BIT / 2);
    send_frame(8'h22, 1'b1, 1'b1);
    drive(1'b1, BIT);
    check("ovr_count", 32'(n_ovr), 32'd1);
    check("ovr_valid", 32'(m_valid), 32'd1);
    check("ovr_data", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    tick_n(1);
    check("ovr_drain", 32'(m_valid), 32'd0);
    check_one_word("ovr_got", 8'h11);

`ifdef UART_RX_PARITY_EN
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    drive(1'b1, BIT);
    check("par_bad_count", 32'(n_perr), 32'd1);
    check("par_bad_rises", 32'(rises), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1);
    drive(1'b1, BIT);
    check_one_word("par_good", 8'h07);
    check("par_good_perr", 32'(n_perr), 32'd1);
`endif

    // Reset during data bit 4 of a frame with a word pending.
    m_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b1);
    drive(1'b1, BIT / 2);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    drive(1'b0, BIT);
    drive(1'b1, BIT); drive(1'b0, BIT); drive(1'b1, BIT); drive(1'b0, BIT);
    drive(1'b1, BIT / 2);
    rst = 1'b1;
    tick_n(1);
    check("mid_rst_out", 32'({m_valid, m_data, frame_err, overrun, parity_err}), 32'd0);
    rst = 1'b0;
    clear_mon();
    m_ready = 1'b1;
    drive(1'b1, 5 * BIT);
    send_frame(8'hF0, 1'b1, 1'b1);
    drive(1'b1, BIT);
    check_one_word("ff0", 8'hF0);
    check("ff0_flags", 32'(n_ferr + n_ovr + n_perr), 32'd0);

    // Random frames with occasional glitches, bad stops and bad parity.
    clear_mon();
    exp_ferr = 0;
    exp_perr = 0;
    for (int k = 0; k < 20; k++) begin
      logic [DATA_BITS-1:0] d;
      bit stop_ok, par_ok;
      d       = DATA_BITS'($urandom);
      stop_ok = $urandom_range(0, 4) != 0;
      par_ok  = (NPAR == 0) || ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b0, $urandom_range(1, 20));
        drive(1'b1, BIT);
      end
      send_frame(d, stop_ok, par_ok);
      if (!par_ok) exp_perr++;
      if (!stop_ok) begin
        exp_ferr++;
        drive(1'b0, $urandom_range(1, 2 * BIT));
      end else if (par_ok) begin
        exp_q.push_back(d);
      end
      drive(1'b1, $urandom_range(BIT / 2, 2 * BIT));
    end
    drive(1'b1, BIT);
    check("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rnd_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("rnd_ferr", 32'(n_ferr), 32'(exp_ferr));
    check("rnd_perr", 32'(n_perr), 32'(exp_perr));
    check("rnd_ovr", 32'(n_ovr), 32'd0);
    check("hold_stable", 32'(stab_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
